// File: rtl/regfile_pkg.sv
// Shared constants and state type for the register-file write port.
// Used by regfile_write_port and decoder5_32.
package regfile_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] ZERO_REG   = 5'd31;
    localparam logic [REG_IDX_W-1:0] CLEAR_LAST = 5'd30;

    typedef enum logic {
        IDLE,
        CLEAR
    } wr_state_t;

endpackage

// File: rtl/decoder5_32.sv
// 5-to-32 one-hot decoder with enable; bit 31 (the zero register) is never set.
module decoder5_32
    import regfile_pkg::*;
(
    input  logic                 i_en,
    input  logic [REG_IDX_W-1:0] i_idx,
    output logic [NUM_REGS-1:0]  o_onehot
);

    // NOTE: assign the default first so every path drives the output and no latch is inferred.
    always_comb begin
        o_onehot = '0;
        if (i_en && (i_idx != ZERO_REG)) begin
            o_onehot[i_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_port.sv
// Write side of the 32 x DATA_W register file with a one-register-per-cycle bulk-clear sequencer.
// Optional macro REGFILE_BYPASS_EN forwards an accepted write to DataOut in the same cycle.
module regfile_write_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               WriteValid,
    output logic                               WriteReady,
    input  logic [REG_IDX_W-1:0]               WriteRegister,
    input  logic [DATA_W-1:0]                  WriteData,
    input  logic                               ClearAll,
    output logic                               ClearBusy,
    output logic [NUM_REGS-1:0][DATA_W-1:0]    DataOut
);

    wr_state_t            r_state;
    wr_state_t            w_next_state;
    logic [REG_IDX_W-1:0] r_cnt;
    logic [REG_IDX_W-1:0] w_next_cnt;

    logic                 w_accept;
    logic [NUM_REGS-1:0]  w_wr_onehot;
    logic [NUM_REGS-1:0]  w_clr_onehot;
    logic                 w_unused_zero_reg_bits;

    // X31 has no storage; only X0..X30 are real flops.
    logic [DATA_W-1:0]    r_regs [NUM_REGS-1];

    // Handshake outputs depend on registered state only.
    assign WriteReady = (r_state == IDLE);
    assign ClearBusy  = (r_state == CLEAR);
    assign w_accept   = WriteValid && WriteReady;

    decoder5_32 u_wr_dec (
        .i_en     (w_accept),
        .i_idx    (WriteRegister),
        .o_onehot (w_wr_onehot)
    );

    decoder5_32 u_clr_dec (
        .i_en     (r_state == CLEAR),
        .i_idx    (r_cnt),
        .o_onehot (w_clr_onehot)
    );

    assign w_unused_zero_reg_bits = w_wr_onehot[NUM_REGS-1] ^ w_clr_onehot[NUM_REGS-1];

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                w_next_cnt = '0;
                if (ClearAll) begin
                    w_next_state = CLEAR;
                end
            end
            CLEAR: begin
                if (r_cnt == CLEAR_LAST) begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 5'd1;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // NOTE: the architectural registers are reset explicitly; an unreset array would read X after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (w_clr_onehot[i]) begin
                    r_regs[i] <= '0;
                end else if (w_wr_onehot[i]) begin
                    r_regs[i] <= WriteData;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS - 1; g++) begin : g_read
`ifdef REGFILE_BYPASS_EN
        assign DataOut[g] = w_wr_onehot[g] ? WriteData : r_regs[g];
`else
        assign DataOut[g] = r_regs[g];
`endif
    end

    assign DataOut[NUM_REGS-1] = '0;

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed self-checking bench for regfile_write_port (default build; bypass expectations follow REGFILE_BYPASS_EN).
module tb_regfile_write_port;

    localparam int DATA_W = 64;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   WriteValid;
    logic                   WriteReady;
    logic [4:0]             WriteRegister;
    logic [DATA_W-1:0]      WriteData;
    logic                   ClearAll;
    logic                   ClearBusy;
    logic [31:0][DATA_W-1:0] DataOut;

    logic [31:0][DATA_W-1:0] exp_regs;
    int checks = 0;
    int errors = 0;

    regfile_write_port #(.DATA_W(DATA_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .WriteValid    (WriteValid),
        .WriteReady    (WriteReady),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ClearAll      (ClearAll),
        .ClearBusy     (ClearBusy),
        .DataOut       (DataOut)
    );

    always #5 clk = ~clk;

    // Index of the first register whose DataOut differs from the model, or -1.
    function automatic int diff_idx();
        for (int i = 0; i < 32; i++) begin
            if (DataOut[i] !== exp_regs[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        WriteValid    = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        ClearAll      = 1'b0;
        reset         = 1'b1;
        exp_regs      = '0;
        #17;
        reset = 1'b0;
        tick();
        checks++;
        if (DataOut !== exp_regs) begin
            errors++;
            $display("FAIL reset_dataout reg %0d got %h expected 0", diff_idx(), DataOut[diff_idx()]);
        end
        checks++;
        if (WriteReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b expected 1", WriteReady);
        end
        checks++;
        if (ClearBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b expected 0", ClearBusy);
        end
    endtask

    task automatic test_write();
        logic [DATA_W-1:0] same_cycle_exp;
        WriteValid    = 1'b1;
        WriteRegister = 5'd5;
        WriteData     = 64'hDEAD_BEEF_0123_4567;
`ifdef REGFILE_BYPASS_EN
        same_cycle_exp = 64'hDEAD_BEEF_0123_4567;
`else
        same_cycle_exp = '0;
`endif
        #1;
        checks++;
        if (DataOut[5] !== same_cycle_exp) begin
            errors++;
            $display("FAIL write_same_cycle got %h expected %h", DataOut[5], same_cycle_exp);
        end
        tick();
        WriteValid  = 1'b0;
        exp_regs[5] = 64'hDEAD_BEEF_0123_4567;
        checks++;
        if (DataOut !== exp_regs) begin
            errors++;
            $display("FAIL write_x5 reg %0d got %h expected %h", diff_idx(), DataOut[diff_idx()], exp_regs[diff_idx()]);
        end
    endtask

    task automatic test_x31();
        WriteValid    = 1'b1;
        WriteRegister = 5'd31;
        WriteData     = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        checks++;
        if (WriteReady !== 1'b1) begin
            errors++;
            $display("FAIL x31_ready got %b expected 1", WriteReady);
        end
        checks++;
        if (DataOut[31] !== 64'h0) begin
            errors++;
            $display("FAIL x31_same_cycle got %h expected 0", DataOut[31]);
        end
        tick();
        WriteValid = 1'b0;
        checks++;
        if (DataOut !== exp_regs) begin
            errors++;
            $display("FAIL x31_after reg %0d got %h expected %h", diff_idx(), DataOut[diff_idx()], exp_regs[diff_idx()]);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 31; r++) begin
            WriteValid    = 1'b1;
            WriteRegister = 5'(r);
            WriteData     = 64'(r);
            #1;
            checks++;
            if (WriteReady !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready reg %0d got %b expected 1", r, WriteReady);
            end
            tick();
            exp_regs[r] = 64'(r);
        end
        WriteValid = 1'b0;
        checks++;
        if (DataOut !== exp_regs) begin
            errors++;
            $display("FAIL b2b_fill reg %0d got %h expected %h", diff_idx(), DataOut[diff_idx()], exp_regs[diff_idx()]);
        end
    endtask

    task automatic test_clear();
        int busy_cycles;
        bit done;
        // Write to X12 in the same cycle ClearAll is sampled: committed, then cleared later.
        WriteValid    = 1'b1;
        WriteRegister = 5'd12;
        WriteData     = 64'hABC;
        ClearAll      = 1'b1;
        tick();
        exp_regs[12]  = 64'hABC;
        ClearAll      = 1'b0;
        WriteRegister = 5'd3;
        WriteData     = 64'h55;
        checks++;
        if (ClearBusy !== 1'b1 || WriteReady !== 1'b0) begin
            errors++;
            $display("FAIL clear_start busy %b ready %b expected busy 1 ready 0", ClearBusy, WriteReady);
        end
        checks++;
        if (DataOut !== exp_regs) begin
            errors++;
            $display("FAIL clear_collide reg %0d got %h expected %h", diff_idx(), DataOut[diff_idx()], exp_regs[diff_idx()]);
        end
        busy_cycles = 1;
        done        = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (k == 4) ClearAll = 1'b1;
            if (k == 5) ClearAll = 1'b0;
            tick();
            if (k < 31) exp_regs[k] = '0;
            checks++;
            if (DataOut !== exp_regs) begin
                errors++;
                $display("FAIL clear_step k %0d reg %0d got %h expected %h", k, diff_idx(), DataOut[diff_idx()], exp_regs[diff_idx()]);
            end
            checks++;
            if (WriteReady !== !ClearBusy) begin
                errors++;
                $display("FAIL clear_ready_busy k %0d ready %b busy %b expected complementary", k, WriteReady, ClearBusy);
            end
            if (ClearBusy === 1'b1) busy_cycles++;
            else done = 1'b1;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL clear_timeout got busy after %0d cycles expected idle", busy_cycles);
        end
        checks++;
        if (busy_cycles !== 31) begin
            errors++;
            $display("FAIL clear_length got %0d expected 31", busy_cycles);
        end
        checks++;
        if (DataOut[3] !== 64'h0 || WriteReady !== 1'b1) begin
            errors++;
            $display("FAIL clear_held_write x3 %h ready %b expected x3 0 ready 1", DataOut[3], WriteReady);
        end
        // The held X3 request completes at the first edge back in IDLE.
        tick();
        WriteValid  = 1'b0;
        exp_regs[3] = 64'h55;
        checks++;
        if (DataOut !== exp_regs) begin
            errors++;
            $display("FAIL clear_retry reg %0d got %h expected %h", diff_idx(), DataOut[diff_idx()], exp_regs[diff_idx()]);
        end
        checks++;
        if (ClearBusy !== 1'b0) begin
            errors++;
            $display("FAIL clear_no_restart got busy %b expected 0", ClearBusy);
        end
    endtask

    task automatic test_reset_mid_clear();
        WriteValid    = 1'b1;
        WriteRegister = 5'd20;
        WriteData     = 64'h20;
        tick();
        exp_regs[20]  = 64'h20;
        WriteValid    = 1'b0;
        ClearAll      = 1'b1;
        tick();
        ClearAll = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            exp_regs[k] = '0;
        end
        checks++;
        if (DataOut !== exp_regs || ClearBusy !== 1'b1) begin
            errors++;
            $display("FAIL midclear_pre reg %0d got %h expected %h busy %b", diff_idx(), DataOut[diff_idx()], exp_regs[diff_idx()], ClearBusy);
        end
        #2;
        reset    = 1'b1;
        exp_regs = '0;
        #1;
        checks++;
        if (DataOut !== exp_regs) begin
            errors++;
            $display("FAIL midclear_async_regs reg %0d got %h expected 0", diff_idx(), DataOut[diff_idx()]);
        end
        checks++;
        if (WriteReady !== 1'b1 || ClearBusy !== 1'b0) begin
            errors++;
            $display("FAIL midclear_async_state ready %b busy %b expected ready 1 busy 0", WriteReady, ClearBusy);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        tick();
        checks++;
        if (ClearBusy !== 1'b0 || DataOut !== exp_regs) begin
            errors++;
            $display("FAIL midclear_abandon busy %b reg %0d got %h expected busy 0 data 0", ClearBusy, diff_idx(), DataOut[diff_idx()]);
        end
        WriteValid    = 1'b1;
        WriteRegister = 5'd9;
        WriteData     = 64'h99;
        tick();
        WriteValid  = 1'b0;
        exp_regs[9] = 64'h99;
        checks++;
        if (DataOut !== exp_regs) begin
            errors++;
            $display("FAIL midclear_resume reg %0d got %h expected %h", diff_idx(), DataOut[diff_idx()], exp_regs[diff_idx()]);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_x31();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
